// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1-style asynchronous serial receiver with framing-error
//                detection and a saturating error counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATAP        = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Rx,
    output logic [DATAP-1:0] RX_byte,
    output logic             REceived,
    output logic             IS_receiving,
    output logic             REcv_error,
    output logic [7:0]       Err_count
);

    localparam int               c_idx_w = (DATAP > 1) ? $clog2(DATAP) : 1;
    localparam logic [15:0]      c_half  = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0]      c_full  = 16'(CLKS_PER_BIT - 1);
    localparam logic [c_idx_w-1:0] c_last  = c_idx_w'(DATAP - 1);
    localparam logic [c_idx_w-1:0] c_one   = c_idx_w'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_STOP     = 3'd3,
        S_ERR_WAIT = 3'd4
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [1:0]         r_sync;
    logic [15:0]        r_cnt, w_cnt_nxt;
    logic [c_idx_w-1:0] r_idx, w_idx_nxt;
    logic [DATAP-1:0]   r_sr, w_sr_nxt;
    logic [DATAP-1:0]   r_byte, w_byte_nxt;
    logic               r_rcv, w_rcv_nxt;
    logic               r_err, w_err_nxt;
    logic [7:0]         r_err_cnt, w_err_cnt_nxt;
    logic               w_rx_s;

    assign w_rx_s = r_sync[1];

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_sr_nxt      = r_sr;
        w_byte_nxt    = r_byte;
        w_rcv_nxt     = 1'b0;
        w_err_nxt     = 1'b0;
        w_err_cnt_nxt = r_err_cnt;
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = 16'd0;
                end
            end
            S_START: begin
                // Re-check the line mid start bit so short glitches are dropped silently
                if (r_cnt == c_half) begin
                    w_cnt_nxt   = 16'd0;
                    w_idx_nxt   = '0;
                    w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (r_cnt == c_full) begin
                    w_sr_nxt  = {w_rx_s, r_sr[DATAP-1:1]};
                    w_cnt_nxt = 16'd0;
                    w_idx_nxt = r_idx + c_one;
                    if (r_idx == c_last) begin
                        w_state_nxt = S_STOP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_STOP: begin
                if (r_cnt == c_full) begin
                    w_cnt_nxt = 16'd0;
                    if (w_rx_s) begin
                        w_byte_nxt  = r_sr;
                        w_rcv_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_err_nxt     = 1'b1;
                        w_err_cnt_nxt = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;
                        w_state_nxt   = S_ERR_WAIT;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_ERR_WAIT: begin
                // A held break reports once; wait for the line to recover
                if (w_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_sync    <= 2'b11;
            r_state   <= S_IDLE;
            r_cnt     <= 16'd0;
            r_idx     <= '0;
            r_sr      <= '0;
            r_byte    <= '0;
            r_rcv     <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            r_sync    <= {r_sync[0], Rx};
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_sr      <= w_sr_nxt;
            r_byte    <= w_byte_nxt;
            r_rcv     <= w_rcv_nxt;
            r_err     <= w_err_nxt;
            r_err_cnt <= w_err_cnt_nxt;
        end
    end

    assign RX_byte      = r_byte;
    assign REceived     = r_rcv;
    assign REcv_error   = r_err;
    assign Err_count    = r_err_cnt;
    assign IS_receiving = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Scoreboard bench for uart_rx at 16 clocks per bit, 8 bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int N = 16;
    localparam int H = N / 2;
    localparam int D = 8;

    logic         Clk = 1'b0;
    logic         Rst_n = 1'b0;
    logic         Rx = 1'b1;
    logic [D-1:0] RX_byte;
    logic         REceived;
    logic         IS_receiving;
    logic         REcv_error;
    logic [7:0]   Err_count;

    uart_rx #(.CLKS_PER_BIT(N), .DATAP(D)) u_dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .Rx           (Rx),
        .RX_byte      (RX_byte),
        .REceived     (REceived),
        .IS_receiving (IS_receiving),
        .REcv_error   (REcv_error),
        .Err_count    (Err_count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit       is_err;
        bit [7:0] data;
        bit [7:0] errcnt;
        int       cyc;
    } exp_t;

    exp_t     sb[$];
    int       cyc = 0;
    int       n_checks = 0;
    int       n_pass = 0;
    int       n_pulses = 0;
    int       last_pulse = 0;
    int       prev_pulse = 0;
    int       busy_rise = -1;
    int       busy_fall = -1;
    bit       busy_prev = 1'b0;
    bit [7:0] model_byte = 8'h00;
    bit [7:0] model_err = 8'h00;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Output monitor: every pulse must match the head of the scoreboard
    always @(negedge Clk) begin
        if (REceived && REcv_error) chk("pulse_overlap", 32'd1, 32'd0);
        if (REceived || REcv_error) begin
            n_pulses++;
            prev_pulse = last_pulse;
            last_pulse = cyc;
            if (sb.size() == 0) begin
                chk("spurious_pulse", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_kind", 32'(REcv_error), 32'(e.is_err));
                chk("rx_byte", 32'(RX_byte), 32'(e.data));
                chk("err_count", 32'(Err_count), 32'(e.errcnt));
                chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (IS_receiving && !busy_prev) busy_rise = cyc;
        if (!IS_receiving && busy_prev) busy_fall = cyc;
        busy_prev = IS_receiving;
    end

    // All stimulus tasks start and end 1 time unit after a rising edge
    task automatic idle(input int n);
        Rx = 1'b1;
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic send_bit(input bit b);
        Rx = b;
        repeat (N) @(posedge Clk);
        #1;
    endtask

    task automatic send_frame(input bit [7:0] d, input bit stop, output int fall);
        exp_t e;
        fall = cyc;
        if (stop) model_byte = d;
        else if (model_err != 8'hFF) model_err = model_err + 8'd1;
        e.is_err = !stop;
        e.data   = model_byte;
        e.errcnt = model_err;
        e.cyc    = fall + 3 + H + (D + 1) * N;
        sb.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < D; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic drain;
        int t = 0;
        while (sb.size() != 0 && t < 400) begin
            @(posedge Clk);
            t++;
        end
        if (t != 0) #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic pulse_reset;
        Rst_n = 1'b0;
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        model_byte = 8'h00;
        model_err  = 8'h00;
    endtask

    initial begin
        int f;
        int p0;
        bit [7:0] partial;

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_rx_byte", 32'(RX_byte), 32'd0);
        chk("reset_received", 32'(REceived), 32'd0);
        chk("reset_error", 32'(REcv_error), 32'd0);
        chk("reset_busy", 32'(IS_receiving), 32'd0);
        chk("reset_err_count", 32'(Err_count), 32'd0);
        Rst_n = 1'b1;
        idle(5);

        // Single good frame with busy-window timing
        send_frame(8'hA5, 1'b1, f);
        idle(4);
        drain();
        chk("a5_busy_rise", 32'(busy_rise), 32'(f + 3));
        chk("a5_busy_fall", 32'(busy_fall), 32'(f + 3 + H + (D + 1) * N));
        chk("a5_pulses", 32'(n_pulses), 32'd1);

        // Short low glitch is rejected silently
        p0 = n_pulses;
        f = cyc;
        Rx = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        idle(30);
        chk("glitch_rise", 32'(busy_rise), 32'(f + 3));
        chk("glitch_busy_len", 32'(busy_fall - busy_rise), 32'(H));
        chk("glitch_no_pulse", 32'(n_pulses), 32'(p0));
        chk("glitch_err_count", 32'(Err_count), 32'd0);
        chk("glitch_byte_held", 32'(RX_byte), 32'hA5);

        // Good frame, framing error, then recovery
        send_frame(8'h11, 1'b1, f);
        send_frame(8'h3C, 1'b0, f);
        idle(4);
        send_frame(8'h5A, 1'b1, f);
        idle(4);
        drain();
        chk("after_err_count", 32'(Err_count), 32'd1);
        chk("after_err_byte", 32'(RX_byte), 32'h5A);

        // Back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1, f);
        send_frame(8'hFF, 1'b1, f);
        idle(4);
        drain();
        chk("b2b_spacing", 32'(last_pulse - prev_pulse), 32'(10 * N));
        chk("b2b_last_byte", 32'(RX_byte), 32'hFF);

        // Reset in the middle of data bit 4
        p0 = n_pulses;
        partial = 8'h96;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(partial[i]);
        Rx = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        pulse_reset();
        chk("midrst_rx_byte", 32'(RX_byte), 32'd0);
        chk("midrst_busy", 32'(IS_receiving), 32'd0);
        chk("midrst_err_count", 32'(Err_count), 32'd0);
        chk("midrst_flags", 32'({REceived, REcv_error}), 32'd0);
        idle(200);
        chk("midrst_no_pulse", 32'(n_pulses), 32'(p0));
        send_frame(8'hC3, 1'b1, f);
        idle(4);
        drain();
        chk("post_rst_byte", 32'(RX_byte), 32'hC3);

        // Error counter saturation
        for (int k = 0; k < 300; k++) begin
            send_frame(8'h55, 1'b0, f);
            idle(4);
            if (k == 254) chk("sat_reach_255", 32'(Err_count), 32'd255);
        end
        drain();
        chk("sat_hold_255", 32'(Err_count), 32'd255);
        chk("sat_byte_held", 32'(RX_byte), 32'hC3);
        pulse_reset();
        chk("sat_cleared", 32'(Err_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning Clk cycles per serial bit period; legal range 4..65535.
REQ-002 SHALL have parameter DATAP, default 8, meaning data bits per frame.
REQ-003 Clk  input  1  sole clock; all logic on rising edge.
REQ-004 Rst_n  input  1  reset, synchronous, active-low.
REQ-005 Rx  input  1  asynchronous serial line, idle high.
REQ-006 RX_byte  output  DATAP  last correctly framed byte, LSB received first.
REQ-007 REceived  output  1  one-cycle pulse; RX_byte newly valid.
REQ-008 IS_receiving  output  1  high while a frame is in progress.
REQ-009 REcv_error  output  1  one-cycle pulse on framing error.
REQ-010 Err_count  output  8  saturating count of framing errors.

Function
REQ-011 Rx SHALL pass through a two-flop synchronizer (flops reset to 1); rx_s denotes its output; all decisions use rx_s only.
REQ-012 States SHALL be IDLE, START, DATA, STOP, ERR_WAIT; 16-bit cycle counter cnt; bit index idx; shift register sr of DATAP bits.
REQ-013 IDLE: IS_receiving=0; rx_s==0 -> START with cnt=0.
REQ-014 START: cnt increments each cycle; at cnt==CLKS_PER_BIT/2-1 (integer division): rx_s==0 -> DATA, cnt=0, idx=0; rx_s==1 -> IDLE, no REcv_error (glitch reject).
REQ-015 DATA: at cnt==CLKS_PER_BIT-1: sr shifts right with rx_s into MSB, cnt=0, idx+1; after sampling bit DATAP-1 -> STOP; otherwise cnt increments.
REQ-016 STOP: at cnt==CLKS_PER_BIT-1: rx_s==1 -> RX_byte<=sr, REceived=1 next cycle, -> IDLE; rx_s==0 -> REcv_error=1 next cycle, RX_byte unchanged, Err_count+1 (saturate at 255), -> ERR_WAIT.
REQ-017 ERR_WAIT: remain until rx_s==1, then -> IDLE; a held-low line (break) produces exactly one REcv_error.
REQ-018 IS_receiving SHALL be 1 in START, DATA, STOP, ERR_WAIT, 0 in IDLE.
REQ-019 REceived and REcv_error SHALL each be high exactly one cycle per frame and never together.
REQ-020 With T0 = first cycle IDLE sees rx_s==0, H=CLKS_PER_BIT/2, N=CLKS_PER_BIT: bit k sampled at T0+H+(k+1)N, stop bit at T0+H+(DATAP+1)N, REceived/REcv_error high at T0+H+(DATAP+1)N+1.
REQ-021 A new start bit SHALL be accepted on the cycle after returning to IDLE (back-to-back frames with one stop bit, no gap required).
REQ-022 RX_byte SHALL hold its value between good frames; it changes only with REceived.
REQ-023 No parity; exactly one stop bit checked; extra stop bits are idle time.

Reset
REQ-024 Rst_n==0 at a rising Clk edge SHALL force: state IDLE, cnt=0, idx=0, sr=0, synchronizer flops=1, RX_byte=0, REceived=0, IS_receiving=0, REcv_error=0, Err_count=0.
REQ-025 Reset mid-frame SHALL abandon the frame with no REceived/REcv_error pulse; if Rx is still low after release, reception restarts from START (partial frame may then error, counted normally).

Verification (CLKS_PER_BIT=16, DATAP=8)
REQ-026 Serial frame 0xA5, 8N1 at 16 clk/bit -> RX_byte=0xA5, one REceived pulse at T0+8+144+1, IS_receiving high T0+1..T0+152.
REQ-027 Rx low 4 cycles then high -> no REceived, no REcv_error, IS_receiving returns 0 by T0+9, Err_count=0.
REQ-028 After good 0x11, frame 0x3C with stop bit 0 then line high -> one REcv_error pulse, RX_byte stays 0x11, Err_count=1, next frame 0x5A received correctly.
REQ-029 Back-to-back 0x00 then 0xFF, one stop bit each, no gap -> two REceived pulses 160 cycles apart, RX_byte 0x00 then 0xFF.
REQ-030 Rst_n low for 1 cycle during data bit 4 of a frame, line high afterwards -> all outputs at reset values, no pulses; following frame 0xC3 received correctly.
REQ-031 300 consecutive framing errors -> Err_count reaches 255 and holds; only Rst_n clears it.
